// File: rtl/dot_matrix_pkg.sv
// Shared types for the 8x8 dot-matrix scanner.
//   ROWS / COLS  : matrix geometry
//   row_idx_t    : index of one display row
//   row_data_t   : pixel bits of one row, bit n = column n, 1 = lit
//   row_onehot() : one-hot active-high row drive for a given row index
package dot_matrix_pkg;

  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 8;

  typedef logic [$clog2(ROWS)-1:0] row_idx_t;
  typedef logic [COLS-1:0]         row_data_t;

  function automatic logic [ROWS-1:0] row_onehot(input row_idx_t r);
    logic [ROWS-1:0] sel;
    sel    = '0;
    sel[r] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/dot_matrix_row_timer.sv
// Row scan timing: clock divider, row counter and frame-wrap detection.
//   clk, rst    : clock, synchronous active-high reset
//   tick        : divider terminal count; the row advances on this cycle's edge
//   row_next    : row that becomes active after the tick
//   wrap        : tick while on the last row (frame boundary)
//   frame_start : registered wrap, high in the cycle row 0 becomes selected
module dot_matrix_row_timer
  import dot_matrix_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic     clk,
  input  logic     rst,
  output logic     tick,
  output row_idx_t row_next,
  output logic     wrap,
  output logic     frame_start
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DivW-1:0] div_q, div_d;
  row_idx_t        row_q;

  always_comb begin
    tick     = (div_q == DivW'(SCAN_DIV - 1));
    div_d    = tick ? '0 : div_q + DivW'(1);
    row_next = row_q + row_idx_t'(1);  // natural wrap 7 -> 0
    wrap     = tick && (row_q == row_idx_t'(ROWS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      row_q       <= '0;
      frame_start <= 1'b0;
    end else begin
      div_q       <= div_d;
      if (tick) row_q <= row_next;
      frame_start <= wrap;
    end
  end

endmodule

// File: rtl/dot_matrix_scan.sv
// Double-buffered 8x8 dot-matrix scanner with flash.
//   clk, rst      : clock, synchronous active-high reset
//   wr_en/wr_row/wr_data : write one row of the back buffer
//   clear         : zero the whole back buffer (wins over wr_en)
//   commit        : request back-to-front copy at the next frame wrap
//   wr_ready      : writes/clear/commit accepted only while high
//   flash         : blink all pixels lit, gated by the blink phase
//   row_sel       : one-hot active-high row drive (registered)
//   col_data      : column drive for the selected row (registered)
//   frame_start   : one-cycle pulse when row 0 becomes selected
module dot_matrix_scan
  import dot_matrix_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  row_idx_t        wr_row,
  input  row_data_t       wr_data,
  input  logic            clear,
  input  logic            commit,
  output logic            wr_ready,
  input  logic            flash,
  output logic [ROWS-1:0] row_sel,
  output row_data_t       col_data,
  output logic            frame_start
);

  localparam int unsigned BlinkW = $clog2(BLINK_FRAMES + 1);

  row_data_t         back_q  [ROWS];
  row_data_t         back_d  [ROWS];
  row_data_t         front_q [ROWS];
  row_data_t         front_d [ROWS];
  logic              pending_q, pending_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic              tick, wrap, swap, flash_on;
  row_idx_t          row_next;
  row_data_t         next_row_data;

  dot_matrix_row_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_row_timer (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .row_next    (row_next),
    .wrap        (wrap),
    .frame_start (frame_start)
  );

  assign wr_ready = ~pending_q;
  assign swap     = wrap & pending_q;

  always_comb begin
    back_d = back_q;
    if (wr_ready) begin
      if (clear)      back_d = '{default: '0};
      else if (wr_en) back_d[wr_row] = wr_data;
    end

    // Back is frozen while a swap is pending, so the copy sees every accepted write.
    front_d = front_q;
    if (swap) front_d = back_q;

    // A commit accepted on the wrap cycle itself waits for the following wrap.
    pending_d = pending_q;
    if (swap)                     pending_d = 1'b0;
    else if (wr_ready && commit)  pending_d = 1'b1;

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (wrap) begin
      if (blink_cnt_q == BlinkW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BlinkW'(1);
      end
    end

    // Use next-state phase/front so row 0 of a new frame already reflects the wrap.
    flash_on      = flash & blink_phase_d;
    next_row_data = swap ? back_q[row_next] : front_q[row_next];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      back_q        <= '{default: '0};
      front_q       <= '{default: '0};
      pending_q     <= 1'b0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      row_sel       <= row_onehot(row_idx_t'(0));
      col_data      <= '0;
    end else begin
      back_q        <= back_d;
      front_q       <= front_d;
      pending_q     <= pending_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      if (tick) begin
        row_sel  <= row_onehot(row_next);
        col_data <= next_row_data | {COLS{flash_on}};
      end
    end
  end

endmodule

// File: tb/tb_dot_matrix_scan.sv
// Self-checking bench for dot_matrix_scan against a frame-level reference model.
module tb_dot_matrix_scan;
  import dot_matrix_pkg::*;

  localparam int unsigned SD       = 4;
  localparam int unsigned BF       = 2;
  localparam int          FrameLen = 8 * SD;

  logic       clk = 1'b0;
  logic       rst, wr_en, clear, commit, flash;
  logic [2:0] wr_row;
  logic [7:0] wr_data, row_sel, col_data;
  logic       wr_ready, frame_start;

  always #5 clk = ~clk;

  dot_matrix_scan #(
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_row      (wr_row),
    .wr_data     (wr_data),
    .clear       (clear),
    .commit      (commit),
    .wr_ready    (wr_ready),
    .flash       (flash),
    .row_sel     (row_sel),
    .col_data    (col_data),
    .frame_start (frame_start)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: time since reset determines the scan position directly.
  logic [7:0] back_m  [8];
  logic [7:0] front_m [8];
  logic [7:0] disp_m;
  bit         pend_m;
  int         t_m;
  int         wraps_m;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%h want=%h", tag, t_m, got, exp);
    end
  endtask

  task automatic model_step();
    int r_next;
    bit ready;
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        back_m[i]  = 8'h00;
        front_m[i] = 8'h00;
      end
      pend_m  = 0;
      disp_m  = 8'h00;
      t_m     = 0;
      wraps_m = 0;
      return;
    end
    ready = !pend_m;
    if (t_m % SD == SD - 1) begin
      r_next = ((t_m + 1) / SD) % 8;
      if (r_next == 0) begin
        wraps_m++;
        if (pend_m) begin
          front_m = back_m;
          pend_m  = 0;
        end
      end
      disp_m = front_m[r_next] | ((flash && ((wraps_m / BF) % 2 == 1)) ? 8'hFF : 8'h00);
    end
    if (ready) begin
      if (clear) begin
        for (int i = 0; i < 8; i++) back_m[i] = 8'h00;
      end else if (wr_en) begin
        back_m[wr_row] = wr_data;
      end
      if (commit) pend_m = 1;
    end
    t_m++;
  endtask

  task automatic check_outputs();
    logic [7:0] sel_exp;
    logic       fs_exp;
    sel_exp = 8'(1 << ((t_m / SD) % 8));
    fs_exp  = (t_m > 0) && (t_m % FrameLen == 0);
    check_eq("row_sel", row_sel, sel_exp);
    check_eq("col_data", col_data, disp_m);
    check_eq("frame_start", {7'b0, frame_start}, {7'b0, fs_exp});
    check_eq("wr_ready", {7'b0, wr_ready}, {7'b0, !pend_m});
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic idle_inputs();
    wr_en  = 0;
    clear  = 0;
    commit = 0;
  endtask

  // Bounded wait for the model's swap to finish; per-cycle checks cover the DUT.
  task automatic wait_ready();
    int k;
    k = 0;
    while (pend_m && k < 2 * FrameLen + 4) begin
      step();
      k++;
    end
    if (pend_m) check_eq("wait_ready_timeout", 8'h01, 8'h00);
  endtask

  task automatic write_row(input logic [2:0] r, input logic [7:0] d);
    wr_en   = 1;
    wr_row  = r;
    wr_data = d;
    step();
    wr_en = 0;
  endtask

  task automatic do_commit();
    commit = 1;
    step();
    commit = 0;
  endtask

  initial begin
    rst     = 1;
    flash   = 0;
    wr_row  = 0;
    wr_data = 0;
    idle_inputs();
    run(3);
    rst = 0;

    // Idle scan after reset: rows step every SD cycles, columns dark.
    run(2 * FrameLen + 3);

    // Write row 3, commit mid-frame, then a blocked write while pending.
    write_row(3'd3, 8'hA5);
    run(5);
    do_commit();
    write_row(3'd3, 8'hFF);
    wait_ready();
    run(FrameLen + 5);
    do_commit();
    wait_ready();
    run(FrameLen + 2);

    // Clear, write and commit in one cycle: clear wins and lands in the swap.
    clear   = 1;
    wr_en   = 1;
    wr_row  = 3'd0;
    wr_data = 8'h0F;
    commit  = 1;
    step();
    idle_inputs();
    wait_ready();
    run(FrameLen + 3);

    // Flash over several blink periods with some content present.
    write_row(3'd1, 8'h81);
    write_row(3'd6, 8'h3C);
    do_commit();
    wait_ready();
    flash = 1;
    run(8 * FrameLen + 7);
    flash = 0;
    run(FrameLen);

    // Randomized traffic, including occasional mid-frame resets.
    for (int i = 0; i < 900; i++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_row  = 3'($urandom);
      wr_data = 8'($urandom);
      clear   = ($urandom_range(0, 40) == 0);
      commit  = ($urandom_range(0, 25) == 0);
      if ($urandom_range(0, 50) == 0) flash = ~flash;
      rst     = ($urandom_range(0, 300) == 0);
      step();
    end
    rst   = 0;
    flash = 0;
    idle_inputs();
    run(3);

    // Reset while a swap is pending: swap abandoned, scan restarts at row 0.
    wait_ready();
    write_row(3'd5, 8'h3C);
    run(7);
    do_commit();
    run(3);
    rst = 1;
    step();
    step();
    rst = 0;
    run(2 * FrameLen + 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dot_matrix_scan.md
DOT_MATRIX_SCAN -- requirements
Module: dot_matrix_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, giving clock cycles per displayed row (minimum 2).
REQ-002 SHALL have parameter BLINK_FRAMES, default 16, giving frames per flash half-period (minimum 1).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; it SHALL be synchronous and active-high.
REQ-005 SHALL have port wr_en, input, 1, back-buffer row write request.
REQ-006 SHALL have port wr_row, input, 3, back-buffer row index.
REQ-007 SHALL have port wr_data, input, 8, row pixel data; bit n is column n; 1 means lit.
REQ-008 SHALL have port clear, input, 1, zero the whole back buffer.
REQ-009 SHALL have port commit, input, 1, request a back-to-front buffer swap.
REQ-010 SHALL have port wr_ready, output, 1, high when writes, clear and commit are accepted.
REQ-011 SHALL have port flash, input, 1, force-all-lit blink enable.
REQ-012 SHALL have port row_sel, output, 8, one-hot active-high row drive.
REQ-013 SHALL have port col_data, output, 8, column drive for the selected row.
REQ-014 SHALL have port frame_start, output, 1, one-cycle pulse when row 0 becomes selected.

Function
REQ-015 SHALL hold two 8x8 buffers: back (written) and front (displayed).
REQ-016 SHALL accept wr_en, clear and commit only in cycles where wr_ready=1; otherwise SHALL ignore them.
REQ-017 SHALL give clear priority over wr_en in the same cycle.
REQ-018 SHALL apply an accepted write or clear before an accepted commit in the same cycle, so the swapped data includes that write or clear.
REQ-019 SHALL drop wr_ready the cycle after commit is accepted and SHALL hold it low until the swap completes.
REQ-020 SHALL use a divider counter 0..SCAN_DIV-1; at its terminal count the row index SHALL advance, wrapping from 7 to 0.
REQ-021 SHALL, on the row 7->0 wrap, copy back to front if a swap is pending, then raise wr_ready the next cycle.
REQ-022 SHALL register row_sel and col_data; both SHALL update in the cycle after the divider terminal count, with col_data = front[row] OR {8{flash_on}}.
REQ-023 SHALL show swapped data from the first row-0 period after the wrap; no frame SHALL mix old and new rows.
REQ-024 SHALL make flash_on = flash AND blink_phase; blink_phase SHALL toggle every BLINK_FRAMES frame wraps, counted whether or not flash is set.
REQ-025 SHALL apply a flash change at the next row update, not mid-row.
REQ-026 SHALL assert frame_start for exactly one cycle, coincident with row_sel becoming 8'h01.

Reset
REQ-027 SHALL, while rst=1, clear both buffers, the divider, row index, blink counter, blink_phase and swap-pending.
REQ-028 SHALL drive reset output values row_sel=8'h01, col_data=8'h00, wr_ready=1, frame_start=0.
REQ-029 SHALL make reset mid-frame or mid-swap-pending abandon the pending swap; scan SHALL restart at row 0, divider 0.

Structure
REQ-030 SHALL place ROWS=8, COLS=8, the row index type and the row-data type in shared package dot_matrix_pkg.
REQ-031 SHALL split the divider, row counter and frame-wrap/frame_start generation into sub-module dot_matrix_row_timer; buffers, handshake and flash stay in the top.

Verification
REQ-032 SHALL check reset: with SCAN_DIV=4 and reset released, row_sel steps 01,02,04..80,01 every 4 cycles, col_data=00 throughout, frame_start pulses every 32 cycles.
REQ-033 SHALL check write and swap: write row 3=8'hA5, commit mid-frame -> wr_ready low until the wrap, then col_data=A5 only while row_sel=08, starting the next frame.
REQ-034 SHALL check blocked writes: write row 3=8'hFF while wr_ready=0 -> ignored; after the next commit, row 3 still shows A5.
REQ-035 SHALL check same-cycle priority: clear, wr_en (row 0=8'h0F) and commit in one cycle -> after the swap, all rows show 00.
REQ-036 SHALL check flash: flash=1 with BLINK_FRAMES=2 -> col_data=FF on every row for 2 frames, then the buffer contents for 2 frames, alternating.
REQ-037 SHALL check reset during a pending swap: assert rst -> wr_ready=1, front stays all 00, row_sel=01 the cycle after rst deasserts.
